// File: rtl/wb_byte_pack_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_byte_pack_master                                       |
// | Purpose  : Packs a valid/ready byte stream into little-endian 32-bit |
// |            words and writes them with single Wishbone cycles, using  |
// |            byte lane selects for unaligned starts and odd lengths.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wb_byte_pack_master #(
  parameter int ADDR_W      = 11,
  parameter int LEN_W       = 12,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i
);

  localparam int TCNT_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;       // next byte address to be filled
  logic [ADDR_W-3:0]   word_addr;  // word address of the word held in pack
  logic [LEN_W-1:0]    rem;        // bytes still to be accepted
  logic [31:0]         pack;
  logic [3:0]          sel;
  logic [TCNT_W-1:0]   tcnt;
  logic [1:0]          lane;
  logic                last_byte;

  assign lane      = addr[1:0];
  // A word is complete when its top lane is filled or the stream ends.
  assign last_byte = (lane == 2'd3) || (rem == LEN_W'(1));

  // State register; async reset drops any bus cycle immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and all outputs, decoded from the current state.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    s_ready_o = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = 4'h0;
    wb_adr_o  = '0;
    wb_dat_o  = 32'h0;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = (len_i != '0) ? S_FILL : S_DONE;
      end
      S_FILL: begin
        busy_o    = 1'b1;
        s_ready_o = 1'b1;
        if (s_valid_i && last_byte) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy_o   = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_sel_o = sel;
        wb_adr_o = {word_addr, 2'b00};
        wb_dat_o = pack;
        if (wb_ack_i)                                state_nxt = S_GAP;
        else if (tcnt == TCNT_W'(ACK_TIMEOUT - 1))   state_nxt = S_ERR;
      end
      S_GAP: begin
        busy_o    = 1'b1;
        state_nxt = (rem == '0) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        err_o     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address/count tracking, lane packing and ack timeout count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr      <= '0;
      word_addr <= '0;
      rem       <= '0;
      pack      <= 32'h0;
      sel       <= 4'h0;
      tcnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && (len_i != '0)) begin
            addr <= start_addr_i;
            rem  <= len_i;
            pack <= 32'h0;
            sel  <= 4'h0;
          end
        end
        S_FILL: begin
          if (s_valid_i) begin
            pack[8*lane +: 8] <= s_data_i;
            sel[lane]         <= 1'b1;
            word_addr         <= addr[ADDR_W-1:2];
            addr              <= addr + ADDR_W'(1);
            rem               <= rem - LEN_W'(1);
            tcnt              <= '0;
          end
        end
        S_WRITE: begin
          if (wb_ack_i) begin
            pack <= 32'h0;
            sel  <= 4'h0;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_byte_pack_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_wb_byte_pack_master                                    |
// | Purpose  : Self-checking bench: table vectors, corner sequences and  |
// |            randomized transfers against a byte-to-word model.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_wb_byte_pack_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] start_addr = '0;
  logic [11:0] len_in = '0;
  logic        busy, done, err;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [10:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_ack = 1'b0;

  wb_byte_pack_master #(.ADDR_W(11), .LEN_W(12), .ACK_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_addr_i(start_addr),
    .len_i(len_in), .busy_o(busy), .done_o(done), .err_o(err),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  typedef struct {
    logic [10:0] sa;
    int          len;
    logic [7:0]  base;
    logic [7:0]  step;
    int          gap;
    int          ackd;
    int          nwr;
    logic [10:0] adr0; logic [31:0] dat0; logic [3:0] sel0;
    logic [10:0] adr1; logic [31:0] dat1; logic [3:0] sel1;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0, err_cnt = 0, stb_cycles = 0, proto_bad = 0;
  int   ack_delay = 1;
  int   wait_cnt = 0;
  logic in_gap = 1'b0;
  wr_t  captured[$];
  wr_t  exp_q[$];
  logic [7:0] byte_buf [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Wishbone slave with programmable ack delay plus bus protocol watch.
  initial begin
    logic [31:0] mask;
    forever begin
      @(negedge clk);
      if (wb_stb) stb_cycles++;
      if (wb_we !== wb_cyc) proto_bad++;
      if (wb_stb && s_ready) proto_bad++;
      if (in_gap && (wb_stb || s_ready)) proto_bad++;
      in_gap = 1'b0;
      if (wb_cyc && wb_stb) begin
        mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
        if ((wb_dat & ~mask) != 32'h0) proto_bad++;
        if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
          wb_ack = 1'b1;
          in_gap = 1'b1;
          captured.push_back('{adr: wb_adr, dat: wb_dat, sel: wb_sel});
        end else begin
          wait_cnt++;
        end
      end else begin
        wb_ack   = 1'b0;
        wait_cnt = 0;
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  // Reference: walk the byte addresses and group bytes sharing a word.
  task automatic model(input logic [10:0] sa, input int len);
    int          cur_word;
    logic [31:0] cd;
    logic [3:0]  cs;
    int          a, w, l;
    exp_q.delete();
    cur_word = -1;
    cd = '0; cs = '0;
    for (int i = 0; i < len; i++) begin
      a = (int'(sa) + i) % 2048;
      w = a / 4;
      l = a % 4;
      if (w != cur_word) begin
        if (cur_word >= 0) exp_q.push_back('{adr: 11'(cur_word * 4), dat: cd, sel: cs});
        cur_word = w; cd = '0; cs = '0;
      end
      cd[8*l +: 8] = byte_buf[i];
      cs[l] = 1'b1;
    end
    if (cur_word >= 0) exp_q.push_back('{adr: 11'(cur_word * 4), dat: cd, sel: cs});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) chk("s_ready_wait_timeout", 32'd1, 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic begin_xfer(input logic [10:0] sa, input int len, input int gap_mode);
    int g;
    captured.delete();
    stb_cycles = 0;
    start_addr = sa;
    len_in     = 12'(len);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      g = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
      repeat (g) begin s_valid = 1'b0; s_data = 8'($urandom); @(negedge clk); end
      send_byte(byte_buf[i]);
    end
  endtask

  task automatic run_xfer(input logic [10:0] sa, input int len, input int gap_mode,
                          output int d_delta, output int e_delta);
    int d0, e0, guard;
    d0 = done_cnt; e0 = err_cnt; guard = 0;
    begin_xfer(sa, len, gap_mode);
    while (done_cnt == d0 && err_cnt == e0 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) chk("xfer_end_timeout", 32'd1, 32'd0);
    @(negedge clk);
    d_delta = done_cnt - d0;
    e_delta = err_cnt - e0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_nwr"}, 32'(captured.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < captured.size(); i++) begin
      chk({tag, "_adr"}, 32'(captured[i].adr), 32'(exp_q[i].adr));
      chk({tag, "_dat"}, captured[i].dat, exp_q[i].dat);
      chk({tag, "_sel"}, 32'(captured[i].sel), 32'(exp_q[i].sel));
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   dd, ed, guard, s0;

    vecs[0] = '{11'h010, 8, 8'h01, 8'h01, 0, 1, 2, 11'h010, 32'h04030201, 4'hF, 11'h014, 32'h08070605, 4'hF};
    vecs[1] = '{11'h003, 3, 8'hAA, 8'h11, 0, 1, 2, 11'h000, 32'hAA000000, 4'h8, 11'h004, 32'h0000CCBB, 4'h3};
    vecs[2] = '{11'h020, 4, 8'h11, 8'h11, 1, 2, 1, 11'h020, 32'h44332211, 4'hF, 11'h000, 32'h0, 4'h0};
    vecs[3] = '{11'h7FE, 4, 8'h50, 8'h01, 0, 0, 2, 11'h7FC, 32'h51500000, 4'hC, 11'h000, 32'h00005352, 4'h3};

    // Reset state
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_bus",   32'({wb_cyc, wb_stb, wb_we}), 32'd0);
    chk("rst_sel",   32'(wb_sel), 32'd0);
    chk("rst_adr",   32'(wb_adr), 32'd0);
    chk("rst_dat",   wb_dat, 32'd0);
    chk("rst_pulse", 32'({done, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test-plan vectors
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].len; i++) byte_buf[i] = vecs[v].base + 8'(i) * vecs[v].step;
      ack_delay = vecs[v].ackd;
      run_xfer(vecs[v].sa, vecs[v].len, vecs[v].gap, dd, ed);
      chk($sformatf("v%0d_nwr", v), 32'(captured.size()), 32'(vecs[v].nwr));
      if (captured.size() >= 1) begin
        chk($sformatf("v%0d_adr0", v), 32'(captured[0].adr), 32'(vecs[v].adr0));
        chk($sformatf("v%0d_dat0", v), captured[0].dat, vecs[v].dat0);
        chk($sformatf("v%0d_sel0", v), 32'(captured[0].sel), 32'(vecs[v].sel0));
      end
      if (vecs[v].nwr == 2 && captured.size() >= 2) begin
        chk($sformatf("v%0d_adr1", v), 32'(captured[1].adr), 32'(vecs[v].adr1));
        chk($sformatf("v%0d_dat1", v), captured[1].dat, vecs[v].dat1);
        chk($sformatf("v%0d_sel1", v), 32'(captured[1].sel), 32'(vecs[v].sel1));
      end
      chk($sformatf("v%0d_done", v), 32'(dd), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(ed), 32'd0);
      chk($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
    end

    // Zero length: done on the next cycle, no bus activity
    s0 = stb_cycles;
    start_addr = 11'h123; len_in = 12'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zlen_done_next", 32'(done), 32'd1);
    chk("zlen_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zlen_done_once", 32'(done), 32'd0);
    chk("zlen_no_stb", 32'(stb_cycles - s0), 32'd0);

    // Ack timeout
    ack_delay = -1;
    for (int i = 0; i < 4; i++) byte_buf[i] = 8'(8'hC0 + i);
    run_xfer(11'h040, 4, 0, dd, ed);
    chk("tmo_stb_cycles", 32'(stb_cycles), 32'd16);
    chk("tmo_err", 32'(ed), 32'd1);
    chk("tmo_no_done", 32'(dd), 32'd0);
    chk("tmo_bus_low", 32'({wb_cyc, wb_stb}), 32'd0);
    chk("tmo_no_writes", 32'(captured.size()), 32'd0);

    // Async reset while strobe is high
    for (int i = 0; i < 4; i++) byte_buf[i] = 8'(8'h70 + i);
    begin_xfer(11'h100, 4, 0);
    guard = 0;
    while (!wb_stb && guard < 50) begin @(negedge clk); guard++; end
    chk("arst_stb_seen", 32'(wb_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus_drop", 32'({wb_cyc, wb_stb}), 32'd0);
    chk("arst_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) byte_buf[i] = 8'(8'h90 + i);
    model(11'h200, 4);
    run_xfer(11'h200, 4, 0, dd, ed);
    cmp_model("arst_after");
    chk("arst_after_done", 32'(dd), 32'd1);

    // Randomized transfers against the reference model
    for (int t = 0; t < 20; t++) begin
      logic [10:0] sa;
      int          len;
      sa  = 11'($urandom_range(0, 2047));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) byte_buf[i] = 8'($urandom);
      ack_delay = int'($urandom_range(0, 3));
      model(sa, len);
      run_xfer(sa, len, -1, dd, ed);
      cmp_model($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d_done", t), 32'(dd), 32'd1);
    end

    chk("protocol_violations", 32'(proto_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
